core_sequencer: RTL and testbench

Parametrised multi-cycle instruction sequencer for the 16-bit core. It owns the PC and the instruction/operand registers, and it drives a single-port memory through a req/ready handshake, so memory can insert wait states. It handles one- and two-word instructions, load/store/wr data accesses, and beq/j control flow. It presents each decoded instruction to the register-file/ALU datapath with a one-cycle exec_valid strobe.

---
 rtl/core_sequencer_if.sv | 41 ++++
 rtl/core_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
//   Single-port memory bus between the instruction sequencer (master) and the
//   memory (slave).
//
//   Handshake: the master raises mem_req together with mem_addr, mem_we and
//   mem_wdata. It holds all of them stable until it samples mem_ready=1 on a
//   rising clock edge. Exactly one transfer completes on each edge where
//   mem_req=1 and mem_ready=1. For reads, mem_rdata is valid only on that
//   edge. The master ignores mem_ready whenever mem_req=0. mem_req never
//   depends combinationally on mem_ready.
//
//   Signals:
//     mem_addr  [ADDR_W]  access address               (master -> slave)
//     mem_req             access request               (master -> slave)
//     mem_we              write qualifier for mem_req  (master -> slave)
//     mem_wdata [DATA_W]  write data                   (master -> slave)
//     mem_ready           transfer completes this edge (slave -> master)
//     mem_rdata [DATA_W]  read data                    (slave -> master)
// -----------------------------------------------------------------------------
interface core_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_req, mem_we, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_req, mem_we, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle instruction sequencer for the 16-bit core. It owns the PC and
//   the instruction and operand registers. It fetches one- and two-word
//   instructions over a wait-state-tolerant memory bus and performs
//   load/store/wr data accesses. It resolves beq/j control flow and presents
//   each instruction to the datapath with a one-cycle exec_valid strobe.
//
//   Ports:
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     bus             memory bus, master side (see core_sequencer_if)
//     reg_a [DATA_W]  datapath A port: store/wr write data
//     reg_b [DATA_W]  datapath B port: wr address
//     eq_flag         ALU equality flag, used only by beq in EXEC
//     instr [DATA_W]  current first instruction word
//     operand[DATA_W] second instruction word (two-word ops), else 0
//     load_data       data returned by the last load
//     load_we         one-cycle pulse: write load_data to register instr[11:8]
//     exec_valid      one-cycle pulse while in EXEC
//     pc [PC_W]       current PC
//     dbg_state [3]   FSM state (BOOT=0 FETCH=1 FETCH2=2 MEM=3 EXEC=4)
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int              DATA_W   = 16,
  parameter int              PC_W     = 16,
  parameter int              ADDR_W   = 24,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  core_sequencer_if.master    bus,
  input  logic [DATA_W-1:0]   reg_a,
  input  logic [DATA_W-1:0]   reg_b,
  input  logic                eq_flag,
  output logic [DATA_W-1:0]   instr,
  output logic [DATA_W-1:0]   operand,
  output logic [DATA_W-1:0]   load_data,
  output logic                load_we,
  output logic                exec_valid,
  output logic [PC_W-1:0]     pc,
  output logic [2:0]          dbg_state
);

  localparam int BANK_W = ADDR_W - PC_W;

  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_J     = 4'd8;
  localparam logic [3:0] OP_WR    = 4'd14;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_FETCH2 = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [3:0]        op;        // opcode of the latched instruction
  logic [3:0]        fetch_op;  // opcode of the word arriving in FETCH
  logic [PC_W-1:0]   pc_p1;
  logic [PC_W-1:0]   pc_p2;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] wr_addr;

  function automatic logic is_two_word(input logic [3:0] o);
    return (o == OP_LOAD) || (o == OP_STORE) || (o == OP_BEQ);
  endfunction

  assign op       = instr[15:12];
  assign fetch_op = bus.mem_rdata[15:12];
  assign pc_p1    = pc + PC_W'(1);   // wraps modulo 2^PC_W
  assign pc_p2    = pc + PC_W'(2);

  // load/store address: bank bits come from the low instruction bits, the
  // in-bank offset from the operand word.
  generate
    if (BANK_W > 0) begin : g_bank
      assign data_addr = {instr[BANK_W-1:0], operand[PC_W-1:0]};
    end else begin : g_nobank
      assign data_addr = operand[PC_W-1:0];
    end
  endgenerate

  // wr takes its full address from the B port (truncated or zero-extended).
  assign wr_addr = ADDR_W'(reg_b);

  assign exec_valid = (state == S_EXEC);
  assign dbg_state  = state;

  // Next state and bus outputs. Bus outputs depend on state and registers
  // only, so they stay stable across wait states, and mem_req has no path
  // from mem_ready.
  always_comb begin
    state_nx      = state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      S_BOOT: begin
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = ADDR_W'(pc);
        if (bus.mem_ready) begin
          if (is_two_word(fetch_op)) state_nx = S_FETCH2;
          else if (fetch_op == OP_WR) state_nx = S_MEM;
          else                        state_nx = S_EXEC;
        end
      end
      S_FETCH2: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = ADDR_W'(pc_p1);
        if (bus.mem_ready) begin
          state_nx = (op == OP_BEQ) ? S_EXEC : S_MEM;
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        if (op == OP_WR) begin
          bus.mem_addr  = wr_addr;
          bus.mem_we    = 1'b1;
          bus.mem_wdata = reg_a;
        end else begin
          bus.mem_addr = data_addr;
          if (op == OP_STORE) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = reg_a;
          end
        end
        if (bus.mem_ready) state_nx = S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_FETCH;
      end
      default: begin
        state_nx = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_BOOT;
      pc        <= RESET_PC;
      instr     <= '0;
      operand   <= '0;
      load_data <= '0;
      load_we   <= 1'b0;
    end else begin
      state   <= state_nx;
      load_we <= 1'b0;
      case (state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            instr <= bus.mem_rdata;
            if (!is_two_word(fetch_op)) operand <= '0;
          end
        end
        S_FETCH2: begin
          if (bus.mem_ready) operand <= bus.mem_rdata;
        end
        S_MEM: begin
          // load_we is registered so it lands in EXEC alongside exec_valid.
          if (bus.mem_ready && (op == OP_LOAD)) begin
            load_data <= bus.mem_rdata;
            load_we   <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op)
            OP_J:               pc <= PC_W'(instr[11:0]);
            OP_BEQ:             pc <= eq_flag ? operand[PC_W-1:0] : pc_p2;
            OP_LOAD, OP_STORE:  pc <= pc_p2;
            default:            pc <= pc_p1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//   Directed bench for core_sequencer (RESET_PC = 0x0010). The bench plays the
//   memory side cycle by cycle: each task drives mem_rdata/mem_ready for the
//   next edge, advances one clock, and checks the outputs 1 ns after the edge.
//   Completed memory writes are collected by a bus monitor and compared against
//   an expected queue at the end.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] reg_a, reg_b;
  logic        eq_flag;
  logic [15:0] instr, operand, load_data;
  logic        load_we, exec_valid;
  logic [15:0] pc;
  logic [2:0]  dbg_state;

  core_sequencer_if #(.DATA_W(16), .ADDR_W(24)) bus ();

  core_sequencer #(
    .DATA_W(16), .PC_W(16), .ADDR_W(24), .RESET_PC(16'h0010)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .reg_a(reg_a), .reg_b(reg_b), .eq_flag(eq_flag),
    .instr(instr), .operand(operand), .load_data(load_data),
    .load_we(load_we), .exec_valid(exec_valid), .pc(pc),
    .dbg_state(dbg_state)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- write scoreboard ----------------
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];

  always @(posedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_we && bus.mem_ready)
      obs_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reg_a = 16'h0; reg_b = 16'h0; eq_flag = 1'b0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_we got=%b exp=0", bus.mem_we); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'h0) $display("FAIL rst_wdata got=%h exp=0000", bus.mem_wdata); else n_pass++;
    n_total++; if (exec_valid !== 1'b0) $display("FAIL rst_exec got=%b exp=0", exec_valid); else n_pass++;
    n_total++; if (load_we !== 1'b0) $display("FAIL rst_load_we got=%b exp=0", load_we); else n_pass++;
    n_total++; if (pc !== 16'h0010) $display("FAIL rst_pc got=%h exp=0010", pc); else n_pass++;
    n_total++; if ({instr, operand, load_data} !== 48'h0) $display("FAIL rst_regs got=%h exp=0", {instr, operand, load_data}); else n_pass++;
    n_total++; if (dbg_state !== 3'd0) $display("FAIL rst_state got=%0d exp=0", dbg_state); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL boot_req got=%b exp=0", bus.mem_req); else n_pass++;
    tick();
    n_total++; if (dbg_state !== 3'd1) $display("FAIL boot_to_fetch got=%0d exp=1", dbg_state); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b1) $display("FAIL first_req got=%b exp=1", bus.mem_req); else n_pass++;
    n_total++; if (bus.mem_addr !== 24'h000010) $display("FAIL first_addr got=%h exp=000010", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL first_we got=%b exp=0", bus.mem_we); else n_pass++;
  endtask

  task automatic test_jump(input logic [15:0] w, input logic [15:0] exp_pc);
    bus.mem_rdata = w; bus.mem_ready = 1'b1;
    tick();
    n_total++; if (exec_valid !== 1'b1) $display("FAIL j_exec got=%b exp=1", exec_valid); else n_pass++;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL j_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (instr !== w) $display("FAIL j_instr got=%h exp=%h", instr, w); else n_pass++;
    tick();
    n_total++; if (pc !== exp_pc) $display("FAIL j_pc got=%h exp=%h", pc, exp_pc); else n_pass++;
    n_total++; if (bus.mem_addr !== {8'h00, exp_pc}) $display("FAIL j_fetch_addr got=%h exp=%h", bus.mem_addr, {8'h00, exp_pc}); else n_pass++;
  endtask

  task automatic test_one_word(input logic [15:0] w, input logic [15:0] exp_pc);
    bus.mem_rdata = w; bus.mem_ready = 1'b1;
    tick();
    n_total++; if (exec_valid !== 1'b1) $display("FAIL ow_exec got=%b exp=1", exec_valid); else n_pass++;
    n_total++; if (operand !== 16'h0000) $display("FAIL ow_operand got=%h exp=0000", operand); else n_pass++;
    n_total++; if (instr !== w) $display("FAIL ow_instr got=%h exp=%h", instr, w); else n_pass++;
    tick();
    n_total++; if (exec_valid !== 1'b0) $display("FAIL ow_exec_pulse got=%b exp=0", exec_valid); else n_pass++;
    n_total++; if (pc !== exp_pc) $display("FAIL ow_pc got=%h exp=%h", pc, exp_pc); else n_pass++;
  endtask

  // load 0x3105 / 0x00A0 at pc=0x0001 with 2 wait states on the data access
  task automatic test_load();
    bus.mem_rdata = 16'h3105; bus.mem_ready = 1'b1;
    tick();
    n_total++; if (bus.mem_addr !== 24'h000002) $display("FAIL ld_f2_addr got=%h exp=000002", bus.mem_addr); else n_pass++;
    bus.mem_rdata = 16'h00A0;
    tick();
    n_total++; if (dbg_state !== 3'd3) $display("FAIL ld_state got=%0d exp=3", dbg_state); else n_pass++;
    n_total++; if (operand !== 16'h00A0) $display("FAIL ld_operand got=%h exp=00a0", operand); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b0) $display("FAIL ld_we got=%b exp=0", bus.mem_we); else n_pass++;
    bus.mem_ready = 1'b0; bus.mem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (bus.mem_addr !== 24'h0500A0) $display("FAIL ld_addr_hold%0d got=%h exp=0500a0", i, bus.mem_addr); else n_pass++;
      n_total++; if (load_we !== 1'b0) $display("FAIL ld_early_we%0d got=%b exp=0", i, load_we); else n_pass++;
      if (i == 2) begin bus.mem_ready = 1'b1; bus.mem_rdata = 16'hBEEF; end
      tick();
    end
    n_total++; if (exec_valid !== 1'b1) $display("FAIL ld_exec got=%b exp=1", exec_valid); else n_pass++;
    n_total++; if (load_we !== 1'b1) $display("FAIL ld_load_we got=%b exp=1", load_we); else n_pass++;
    n_total++; if (load_data !== 16'hBEEF) $display("FAIL ld_data got=%h exp=beef", load_data); else n_pass++;
    tick();
    n_total++; if (load_we !== 1'b0) $display("FAIL ld_we_pulse got=%b exp=0", load_we); else n_pass++;
    n_total++; if (pc !== 16'h0003) $display("FAIL ld_pc got=%h exp=0003", pc); else n_pass++;
  endtask

  task automatic test_beq(input logic [15:0] opnd, input logic eq,
                          input logic [15:0] exp_f2, input logic [15:0] exp_pc);
    eq_flag = ~eq;   // wrong value outside EXEC must not matter
    bus.mem_rdata = 16'h7000; bus.mem_ready = 1'b1;
    tick();
    n_total++; if (bus.mem_addr !== {8'h00, exp_f2}) $display("FAIL beq_f2_addr got=%h exp=%h", bus.mem_addr, {8'h00, exp_f2}); else n_pass++;
    bus.mem_rdata = opnd;
    tick();
    eq_flag = eq;
    n_total++; if (exec_valid !== 1'b1) $display("FAIL beq_exec got=%b exp=1", exec_valid); else n_pass++;
    n_total++; if (operand !== opnd) $display("FAIL beq_operand got=%h exp=%h", operand, opnd); else n_pass++;
    tick();
    eq_flag = ~eq;
    n_total++; if (pc !== exp_pc) $display("FAIL beq_pc got=%h exp=%h", pc, exp_pc); else n_pass++;
  endtask

  // wr at pc=0x0006
  task automatic test_wr();
    reg_a = 16'h1234; reg_b = 16'h0077;
    bus.mem_rdata = 16'hE5FF; bus.mem_ready = 1'b1;
    tick();
    n_total++; if (dbg_state !== 3'd3) $display("FAIL wr_state got=%0d exp=3", dbg_state); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b1) $display("FAIL wr_we got=%b exp=1", bus.mem_we); else n_pass++;
    n_total++; if (bus.mem_addr !== 24'h000077) $display("FAIL wr_addr got=%h exp=000077", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'h1234) $display("FAIL wr_wdata got=%h exp=1234", bus.mem_wdata); else n_pass++;
    n_total++; if (operand !== 16'h0000) $display("FAIL wr_operand got=%h exp=0000", operand); else n_pass++;
    exp_q.push_back({24'h000077, 16'h1234});
    tick();
    n_total++; if (exec_valid !== 1'b1) $display("FAIL wr_exec got=%b exp=1", exec_valid); else n_pass++;
    n_total++; if (load_we !== 1'b0) $display("FAIL wr_load_we got=%b exp=0", load_we); else n_pass++;
    tick();
    n_total++; if (pc !== 16'h0007) $display("FAIL wr_pc got=%h exp=0007", pc); else n_pass++;
  endtask

  // store 0x4203 / 0x1111 at pc=0x0007 with 1 wait state
  task automatic test_store();
    reg_a = 16'h5A5A; reg_b = 16'h0000;
    bus.mem_rdata = 16'h4203; bus.mem_ready = 1'b1;
    tick();
    n_total++; if (bus.mem_addr !== 24'h000008) $display("FAIL st_f2_addr got=%h exp=000008", bus.mem_addr); else n_pass++;
    bus.mem_rdata = 16'h1111;
    tick();
    bus.mem_ready = 1'b0;
    n_total++; if (bus.mem_addr !== 24'h031111) $display("FAIL st_addr got=%h exp=031111", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_we !== 1'b1) $display("FAIL st_we got=%b exp=1", bus.mem_we); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'h5A5A) $display("FAIL st_wdata got=%h exp=5a5a", bus.mem_wdata); else n_pass++;
    tick();
    n_total++; if ({bus.mem_addr, bus.mem_we} !== {24'h031111, 1'b1}) $display("FAIL st_hold got=%h exp=%h", {bus.mem_addr, bus.mem_we}, {24'h031111, 1'b1}); else n_pass++;
    bus.mem_ready = 1'b1;
    exp_q.push_back({24'h031111, 16'h5A5A});
    tick();
    n_total++; if (exec_valid !== 1'b1) $display("FAIL st_exec got=%b exp=1", exec_valid); else n_pass++;
    tick();
    n_total++; if (pc !== 16'h0009) $display("FAIL st_pc got=%h exp=0009", pc); else n_pass++;
  endtask

  // two-word load fetched at pc=0xFFFF: second word comes from address 0
  task automatic test_pc_wrap_two_word();
    bus.mem_rdata = 16'h3105; bus.mem_ready = 1'b1;
    tick();
    n_total++; if (bus.mem_addr !== 24'h000000) $display("FAIL wrap_f2_addr got=%h exp=000000", bus.mem_addr); else n_pass++;
    bus.mem_rdata = 16'h0010;
    tick();
    n_total++; if (bus.mem_addr !== 24'h050010) $display("FAIL wrap_ld_addr got=%h exp=050010", bus.mem_addr); else n_pass++;
    bus.mem_rdata = 16'h4242;
    tick();
    n_total++; if ({load_we, load_data} !== {1'b1, 16'h4242}) $display("FAIL wrap_ld_data got=%h exp=%h", {load_we, load_data}, {1'b1, 16'h4242}); else n_pass++;
    tick();
    n_total++; if (pc !== 16'h0001) $display("FAIL wrap_ld_pc got=%h exp=0001", pc); else n_pass++;
  endtask

  // load at pc=0x0000, reset asserted during a data wait state
  task automatic test_reset_abort();
    bus.mem_rdata = 16'h3105; bus.mem_ready = 1'b1;
    tick();
    bus.mem_rdata = 16'h00A0;
    tick();
    bus.mem_ready = 1'b0;
    tick();
    n_total++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 24'h0500A0}) $display("FAIL abort_pre got=%h exp=%h", {bus.mem_req, bus.mem_addr}, {1'b1, 24'h0500A0}); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bus.mem_req !== 1'b0) $display("FAIL abort_req got=%b exp=0", bus.mem_req); else n_pass++;
    n_total++; if (dbg_state !== 3'd0) $display("FAIL abort_state got=%0d exp=0", dbg_state); else n_pass++;
    n_total++; if (pc !== 16'h0010) $display("FAIL abort_pc got=%h exp=0010", pc); else n_pass++;
    bus.mem_ready = 1'b1; bus.mem_rdata = 16'h9999;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_total++; if ({load_we, exec_valid} !== 2'b00) $display("FAIL abort_strobes got=%b exp=00", {load_we, exec_valid}); else n_pass++;
    tick();
    n_total++; if (bus.mem_addr !== 24'h000010) $display("FAIL abort_restart got=%h exp=000010", bus.mem_addr); else n_pass++;
    n_total++; if ({load_we, load_data} !== 17'h0) $display("FAIL abort_load got=%h exp=0", {load_we, load_data}); else n_pass++;
  endtask

  task automatic test_scoreboard();
    n_total++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL wr_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [39:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL wr_txn got=%h exp=%h", o, e); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();                                   // pc 0x0010
    test_jump(16'h8000, 16'h0000);                  // -> 0x0000
    test_one_word(16'h0123, 16'h0001);              // add at 0x0000
    test_load();                                    // -> 0x0003
    test_one_word(16'h2345, 16'h0004);              // operand cleared after load
    test_beq(16'h0040, 1'b1, 16'h0005, 16'h0040);   // taken
    test_jump(16'h8004, 16'h0004);
    test_beq(16'h0040, 1'b0, 16'h0005, 16'h0006);   // not taken
    test_wr();                                      // -> 0x0007
    test_store();                                   // -> 0x0009
    test_jump(16'h8ABC, 16'h0ABC);
    test_beq(16'hFFFF, 1'b1, 16'h0ABD, 16'hFFFF);
    test_pc_wrap_two_word();                        // -> 0x0001
    test_beq(16'hFFFF, 1'b1, 16'h0002, 16'hFFFF);
    test_one_word(16'h0123, 16'h0000);              // wrap to 0
    test_reset_abort();
    test_scoreboard();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
